// File: rtl/led_sequencer.sv
// Pattern controller for the 10-LED bank: PASS/ROTATE/BOUNCE/COUNT modes stepped on a
// prescaled tick, with synchronized pushbuttons for load, next-mode and run/pause.
module led_sequencer #(
    parameter int TICK_DIV = 5000000,
    parameter int CNT_W    = $clog2(TICK_DIV)
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [9:0] SW,
    input  logic [3:0] KEY,
    output logic [9:0] LED,
    output logic [1:0] mode,
    output logic       running
);

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_ROTATE = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [2:0]       key_s1_q, key_s2_q, key_hist_q;
    logic [2:0]       press;
    logic             load_p, next_p, run_p, tick;
    mode_e            mode_q, mode_d;
    logic             running_q, running_d;
    logic [9:0]       led_q, led_d;
    logic [9:0]       pattern_q, pattern_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            key_s1_q   <= 3'b111;
            key_s2_q   <= 3'b111;
            key_hist_q <= 3'b111;
            mode_q     <= MODE_PASS;
            running_q  <= 1'b1;
            led_q      <= '0;
            pattern_q  <= '0;
            dir_q      <= DIR_LEFT;
            cnt_q      <= '0;
        end else begin
            key_s1_q   <= KEY[3:1];
            key_s2_q   <= key_s1_q;
            key_hist_q <= key_s2_q;
            mode_q     <= mode_d;
            running_q  <= running_d;
            led_q      <= led_d;
            pattern_q  <= pattern_d;
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
        end
    end

    // One-cycle pulse per falling edge of each synchronized, active-low key.
    assign press  = ~key_s2_q & key_hist_q;
    assign load_p = press[0];
    assign next_p = press[1];
    assign run_p  = press[2];

    always_comb begin
        mode_d    = mode_q;
        running_d = running_q ^ run_p;
        led_d     = led_q;
        pattern_d = pattern_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        tick      = 1'b0;

        if (running_q && (mode_q != MODE_PASS)) begin
            if (cnt_q == CNT_LAST) begin
                tick  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (mode_q == MODE_PASS) led_d = SW;
        if (load_p) pattern_d = SW;

        // Mode press outranks load press, which outranks a tick; both discard the tick.
        if (next_p) begin
            cnt_d  = '0;
            mode_d = mode_e'(2'(mode_q + 2'd1));
            case (mode_d)
                MODE_PASS:   led_d = SW;
                MODE_ROTATE: led_d = pattern_d;
                MODE_BOUNCE: begin
                    led_d = 10'b00_0000_0001;
                    dir_d = DIR_LEFT;
                end
                default:     led_d = '0;
            endcase
        end else if (load_p) begin
            cnt_d = '0;
            if (mode_q == MODE_ROTATE) led_d = SW;
        end else if (tick) begin
            case (mode_q)
                MODE_ROTATE: led_d = {led_q[8:0], led_q[9]};
                MODE_BOUNCE: begin
                    if (dir_q == DIR_LEFT) begin
                        if (led_q[9]) begin
                            dir_d = DIR_RIGHT;
                            led_d = led_q >> 1;
                        end else begin
                            led_d = led_q << 1;
                        end
                    end else begin
                        if (led_q[0]) begin
                            dir_d = DIR_LEFT;
                            led_d = led_q << 1;
                        end else begin
                            led_d = led_q >> 1;
                        end
                    end
                end
                MODE_COUNT:  led_d = led_q + 10'd1;
                default:     led_d = led_q;
            endcase
        end
    end

    assign LED     = led_q;
    assign mode    = mode_q;
    assign running = running_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed self-checking bench for led_sequencer with a 4-cycle pattern step.
module tb_led_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] SW;
    logic [3:0] KEY;
    logic [9:0] LED;
    logic [1:0] mode;
    logic       running;

    int n_checks = 0;
    int n_fail   = 0;

    led_sequencer #(.TICK_DIV(4)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .SW       (SW),
        .KEY      (KEY),
        .LED      (LED),
        .mode     (mode),
        .running  (running)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Key low for three edges: sync, pulse, effect; effect is visible on return.
    task automatic press(input int k);
        KEY[k] = 1'b0;
        cyc(3);
        KEY[k] = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        SW    = '0;
        KEY   = 4'hF;

        // Reset and PASS
        cyc(2);
        check("rst_led", 32'(LED), 32'h000);
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_running", 32'(running), 32'd1);
        reset = 1'b0;
        SW    = 10'h2A5;
        cyc(1);
        check("pass_led", 32'(LED), 32'h2A5);
        check("pass_mode", 32'(mode), 32'd0);

        // Load and ROTATE
        SW = 10'h001;
        press(2);
        check("rot_mode", 32'(mode), 32'd1);
        check("rot_init_led", 32'(LED), 32'h000);
        cyc(3);
        press(1);
        check("rot_load", 32'(LED), 32'h001);
        cyc(3);
        check("rot_hold", 32'(LED), 32'h001);
        cyc(1);
        check("rot_step1", 32'(LED), 32'h002);
        cyc(32);
        check("rot_bit9", 32'(LED), 32'h200);
        cyc(4);
        check("rot_wrap", 32'(LED), 32'h001);

        // Load coinciding with a tick: load wins, prescaler restarts
        SW = 10'h0F0;
        cyc(1);
        press(1);
        check("coinc_load", 32'(LED), 32'h0F0);
        cyc(3);
        check("coinc_hold", 32'(LED), 32'h0F0);
        cyc(1);
        check("coinc_step", 32'(LED), 32'h1E0);

        // BOUNCE
        do_reset();
        press(2);
        cyc(3);
        press(2);
        check("bnc_mode", 32'(mode), 32'd2);
        check("bnc_init", 32'(LED), 32'h001);
        cyc(36);
        check("bnc_top", 32'(LED), 32'h200);
        cyc(4);
        check("bnc_turn", 32'(LED), 32'h100);
        cyc(32);
        check("bnc_bottom", 32'(LED), 32'h001);
        cyc(4);
        check("bnc_turn_up", 32'(LED), 32'h002);

        // COUNT wrap and pause/resume
        do_reset();
        press(2);
        cyc(3);
        press(2);
        cyc(3);
        press(2);
        check("cnt_mode", 32'(mode), 32'd3);
        check("cnt_init", 32'(LED), 32'h000);
        cyc(4092);
        check("cnt_max", 32'(LED), 32'h3FF);
        cyc(4);
        check("cnt_wrap", 32'(LED), 32'h000);
        press(3);
        check("pause_running", 32'(running), 32'd0);
        check("pause_led", 32'(LED), 32'h000);
        cyc(23);
        check("pause_hold", 32'(LED), 32'h000);
        press(3);
        check("resume_running", 32'(running), 32'd1);
        check("resume_led", 32'(LED), 32'h000);
        cyc(1);
        check("resume_step", 32'(LED), 32'h001);
        cyc(4);
        check("resume_step2", 32'(LED), 32'h002);

        // Mode and load together
        do_reset();
        SW     = 10'h3C3;
        KEY[2] = 1'b0;
        KEY[1] = 1'b0;
        cyc(3);
        KEY    = 4'hF;
        check("both_mode", 32'(mode), 32'd1);
        SW = 10'h011;
        cyc(3);
        press(2);
        cyc(3);
        press(2);
        cyc(3);
        press(2);
        check("both_pass_mode", 32'(mode), 32'd0);
        check("both_pass_led", 32'(LED), 32'h011);
        cyc(3);
        press(2);
        check("both_pattern", 32'(LED), 32'h3C3);

        // Held key
        do_reset();
        KEY[2] = 1'b0;
        cyc(50);
        check("held_mode", 32'(mode), 32'd1);
        KEY[2] = 1'b1;
        cyc(3);
        check("held_release", 32'(mode), 32'd1);

        // Reset mid-sequence
        do_reset();
        press(2);
        cyc(3);
        press(2);
        cyc(3);
        press(2);
        cyc(1364);
        check("mid_led", 32'(LED), 32'h155);
        press(3);
        check("mid_paused", 32'(running), 32'd0);
        check("mid_paused_led", 32'(LED), 32'h155);
        do_reset();
        check("mid_rst_led", 32'(LED), 32'h000);
        check("mid_rst_mode", 32'(mode), 32'd0);
        check("mid_rst_running", 32'(running), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
